serial_receiver: RTL and testbench

//  Deserializer for the NeXT monitor serial link; counterpart of the packet sender.

---
 rtl/serial_receiver.sv | 94 +++++++++
 tb/tb_serial_receiver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - NeXT monitor link deserializer with one-entry valid/ready output
module serial_receiver #(
  parameter int         DATA_W     = 40,
  parameter int         GAP_CYCLES = 3,
  parameter logic [7:0] AUDIO_CMD  = 8'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_valid,
  input  logic              out_data_ready,
  output logic              audio_request,
  output logic              data_loss,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [5:0] BIT_LAST   = 6'(DATA_W - 1);
  localparam logic [5:0] GAP_LAST   = 6'(GAP_CYCLES - 1);
  localparam state_t     DONE_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t            state;
  state_t            state_next;
  logic [5:0]        count;
  logic [DATA_W-1:0] shift_reg;
  logic              pkt_last;
  logic              pkt_done;
  logic              shift_en;

  // State register plus the datapath registers that follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      shift_reg <= '0;
      pkt_done  <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      pkt_done <= pkt_last;
      if (shift_en) begin
        shift_reg <= {shift_reg[DATA_W-2:0], sin};
      end
      case (state)
        SHIFT:   count <= pkt_last ? 6'd0 : count + 6'd1;
        GAP:     count <= count + 6'd1;
        default: count <= '0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sin) state_next = SHIFT;
      SHIFT:   if (count == BIT_LAST) state_next = DONE_STATE;
      GAP:     if (count == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == SHIFT);
    pkt_last = (state == SHIFT) && (count == BIT_LAST);
  end

  // Completion is acted on the edge after the last payload bit; shift_reg is
  // guaranteed stable then since the earliest next shift is one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= '0;
      out_data_valid <= 1'b0;
      audio_request  <= 1'b0;
      data_loss      <= 1'b0;
    end else begin
      audio_request <= pkt_done && (shift_reg[DATA_W-1 -: 8] == AUDIO_CMD);
      data_loss     <= pkt_done && out_data_valid && !out_data_ready;
      if (pkt_done && (!out_data_valid || out_data_ready)) begin
        out_data       <= shift_reg;
        out_data_valid <= 1'b1;
      end else if (out_data_valid && out_data_ready) begin
        out_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed self-checking bench for serial_receiver
module tb_serial_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [39:0] out_data;
  logic        out_data_valid;
  logic        out_data_ready;
  logic        audio_request;
  logic        data_loss;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [39:0] P1 = 40'h07_1234_5678;
  localparam logic [39:0] P2 = 40'hA5_0000_00FF;
  localparam logic [39:0] P3 = 40'h3C_DEAD_BEEF;
  localparam logic [39:0] P4 = 40'h07_CAFE_0001;

  serial_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .sin            (sin),
    .out_data       (out_data),
    .out_data_valid (out_data_valid),
    .out_data_ready (out_data_ready),
    .audio_request  (audio_request),
    .data_loss      (data_loss),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Start bit on edge T, payload MSB first on edges T+1..T+40.
  task automatic send_packet(input logic [39:0] p);
    @(negedge clk);
    sin = 1'b1;
    for (int i = 39; i >= 0; i--) begin
      @(negedge clk);
      sin = p[i];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sin = 1'b0;
    out_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_data_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_audio", audio_request, 0);
    check_eq("rst_loss", data_loss, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: audio packet, consumer not ready
    send_packet(P1);
    @(negedge clk); sin = 1'b0;
    check_eq("t1_valid_early", out_data_valid, 0);
    check_eq("t1_busy_gap", busy, 1);
    @(negedge clk);
    check_eq("t1_valid", out_data_valid, 1);
    check_eq("t1_data", out_data, P1);
    check_eq("t1_audio", audio_request, 1);
    check_eq("t1_loss", data_loss, 0);
    @(negedge clk);
    check_eq("t1_audio_pulse", audio_request, 0);
    check_eq("t1_valid_held", out_data_valid, 1);
    out_data_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_valid_consumed", out_data_valid, 0);
    check_eq("t1_busy_idle", busy, 0);

    // 2: non-audio packet, ready held high
    send_packet(P2);
    @(negedge clk); sin = 1'b0;
    @(negedge clk);
    check_eq("t2_valid", out_data_valid, 1);
    check_eq("t2_data", out_data, P2);
    check_eq("t2_audio", audio_request, 0);
    @(negedge clk);
    check_eq("t2_valid_single", out_data_valid, 0);
    out_data_ready = 1'b0;

    // 3 + 5: back-to-back with sin high through the gap, consumer stalled
    send_packet(P1);
    @(negedge clk); sin = 1'b1;
    check_eq("t5_busy_gap", busy, 1);
    @(negedge clk); sin = 1'b1;
    check_eq("t3_first_data", out_data, P1);
    check_eq("t3_first_loss", data_loss, 0);
    @(negedge clk); sin = 1'b1;
    send_packet(P3);
    @(negedge clk); sin = 1'b0;
    @(negedge clk);
    check_eq("t3_valid", out_data_valid, 1);
    check_eq("t3_data_kept", out_data, P1);
    check_eq("t3_loss", data_loss, 1);
    check_eq("t3_audio", audio_request, 0);
    @(negedge clk);
    check_eq("t3_loss_pulse", data_loss, 0);
    out_data_ready = 1'b1;
    @(negedge clk);
    out_data_ready = 1'b0;
    check_eq("t3_drained", out_data_valid, 0);

    // 4: ready asserted exactly on the second completion edge
    send_packet(P4);
    @(negedge clk); sin = 1'b0;
    @(negedge clk);
    check_eq("t4_first_data", out_data, P4);
    check_eq("t4_first_audio", audio_request, 1);
    @(negedge clk);
    send_packet(P2);
    @(negedge clk); sin = 1'b0;
    out_data_ready = 1'b1;
    @(negedge clk);
    out_data_ready = 1'b0;
    check_eq("t4_data", out_data, P2);
    check_eq("t4_valid", out_data_valid, 1);
    check_eq("t4_loss", data_loss, 0);
    check_eq("t4_audio", audio_request, 0);
    @(negedge clk);
    check_eq("t4_stable_data", out_data, P2);
    check_eq("t4_stable_valid", out_data_valid, 1);

    // 6: reset mid-shift discards the packet in flight
    @(negedge clk); sin = 1'b1;
    for (int i = 39; i >= 20; i--) begin
      @(negedge clk);
      sin = P1[i];
    end
    @(negedge clk); rst = 1'b1; sin = 1'b1;
    @(negedge clk);
    check_eq("t6_valid", out_data_valid, 0);
    check_eq("t6_data", out_data, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_audio", audio_request, 0);
    check_eq("t6_loss", data_loss, 0);
    rst = 1'b0; sin = 1'b0;
    repeat (45) @(negedge clk);
    check_eq("t6_no_ghost", out_data_valid, 0);
    check_eq("t6_idle", busy, 0);
    send_packet(P3);
    @(negedge clk); sin = 1'b0;
    @(negedge clk);
    check_eq("t6_clean_valid", out_data_valid, 1);
    check_eq("t6_clean_data", out_data, P3);
    check_eq("t6_clean_loss", data_loss, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
